// File: rtl/clock_divider_multi.sv
// ==========================================================================
// clock_divider_multi -- N-channel clock divider with glitch-free divisor reload
// Optional macro CLKDIV_PHASE_SYNC_EN adds sync_in for phase alignment. Rev 1.0
// ==========================================================================
`default_nettype none

module clock_divider_multi #(
  parameter int CHANNELS    = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                wr_en,
  input  logic [2:0]          wr_ch,
  input  logic [DIV_W-1:0]    wr_data,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic                sync_in,
`endif
  output logic [CHANNELS-1:0] div_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] busy
);

  localparam logic [DIV_W-1:0] c_def_div = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] c_one     = DIV_W'(1);

  logic w_sync;
`ifdef CLKDIV_PHASE_SYNC_EN
  assign w_sync = sync_in & ena;
`else
  assign w_sync = 1'b0;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] shd_q, shd_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    logic             w_live;
    logic             w_wrap;
    logic             w_hit;
    logic [DIV_W:0]   w_half;

    // Channel-select decode also drops any index >= CHANNELS.
    assign w_hit  = wr_en && (wr_ch == 3'(i));
    assign w_live = (act_q != '0);
    assign w_wrap = w_live && (cnt_q == act_q - c_one);
    assign w_half = ({1'b0, act_q} + {{DIV_W{1'b0}}, 1'b1}) >> 1;

    always_comb begin
      act_d  = act_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      cnt_d  = cnt_q;
      div_d  = div_q;
      tick_d = tick_q;
      if (ena) begin
        div_d  = w_live && ({1'b0, cnt_q} < w_half);
        tick_d = w_wrap;
        if (!w_live || w_wrap || w_sync) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + c_one;
        end
        if (pend_q && (w_wrap || w_sync)) begin
          act_d  = shd_q;
          pend_d = 1'b0;
        end
      end
      // A disabled channel has no period to protect, so it loads at once.
      if (w_hit) begin
        if (!w_live) begin
          act_d = wr_data;
          cnt_d = '0;
        end else begin
          shd_d  = wr_data;
          pend_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        act_q  <= c_def_div;
        shd_q  <= '0;
        pend_q <= 1'b0;
        cnt_q  <= '0;
        div_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        act_q  <= act_d;
        shd_q  <= shd_d;
        pend_q <= pend_d;
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        tick_q <= tick_d;
      end
    end

    assign div_out[i] = div_q;
    assign tick[i]    = tick_q;
    assign busy[i]    = pend_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: vector table, hand corner sequences, random run vs model.
`default_nettype none

module tb_clock_divider_multi;
  localparam int CH  = 4;
  localparam int DW  = 8;
  localparam int DEF = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b1;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_ch = '0;
  logic [DW-1:0] wr_data = '0;
  logic          sync_in = 1'b0;
  logic [CH-1:0] div_out, tick, busy;

  always #5 clk = ~clk;

  clock_divider_multi #(.CHANNELS(CH), .DIV_W(DW), .DEFAULT_DIV(DEF)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_data (wr_data),
`ifdef CLKDIV_PHASE_SYNC_EN
    .sync_in (sync_in),
`endif
    .div_out (div_out),
    .tick    (tick),
    .busy    (busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: divisor, shadow, position within the period, registered outputs.
  int m_act[CH];
  int m_shd[CH];
  int m_cnt[CH];
  bit m_pend[CH];
  bit m_div[CH];
  bit m_tick[CH];

  typedef struct packed {
    logic          rst;
    logic          ena;
    logic          we;
    logic [2:0]    ch;
    logic [DW-1:0] d;
    logic [CH-1:0] ediv;
    logic [CH-1:0] etick;
    logic [CH-1:0] ebusy;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic model_step();
    bit sy;
    int old_act;
    bit hit;
    sy = 1'b0;
`ifdef CLKDIV_PHASE_SYNC_EN
    sy = sync_in && ena;
`endif
    for (int c = 0; c < CH; c++) begin
      old_act = m_act[c];
      hit = wr_en && (int'(wr_ch) == c);
      if (rst) begin
        m_act[c] = DEF; m_shd[c] = 0; m_pend[c] = 0;
        m_cnt[c] = 0;   m_div[c] = 0; m_tick[c] = 0;
      end else begin
        if (ena) begin
          if (old_act == 0) begin
            m_div[c] = 0; m_tick[c] = 0; m_cnt[c] = 0;
          end else begin
            m_div[c]  = m_cnt[c] < (old_act + 1) / 2;
            m_tick[c] = m_cnt[c] == old_act - 1;
            m_cnt[c]  = sy ? 0 : (m_cnt[c] + 1) % old_act;
            if (m_pend[c] && m_cnt[c] == 0) begin
              m_act[c] = m_shd[c]; m_pend[c] = 0;
            end
          end
        end
        if (hit) begin
          if (old_act == 0) begin
            m_act[c] = int'(wr_data); m_cnt[c] = 0;
          end else begin
            m_shd[c] = int'(wr_data); m_pend[c] = 1;
          end
        end
      end
    end
  endtask

  task automatic cycle();
    logic [CH-1:0] ed, et, eb;
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) begin
      ed[c] = m_div[c]; et[c] = m_tick[c]; eb[c] = m_pend[c];
    end
    chk("model_div",  8'(div_out), 8'(ed));
    chk("model_tick", 8'(tick),    8'(et));
    chk("model_busy", 8'(busy),    8'(eb));
  endtask

  initial begin
    logic [4:0] e5d, e5t;
    logic [3:0] erd, ert;
    for (int c = 0; c < CH; c++) begin
      m_act[c] = DEF; m_shd[c] = 0; m_cnt[c] = 0;
      m_pend[c] = 0; m_div[c] = 0; m_tick[c] = 0;
    end

    //              rst  ena  we   ch    d      div    tick   busy
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 4'hF, 4'h0, 4'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 4'h0, 4'hF, 4'h0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 4'hF, 4'h0, 4'h0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 4'h0, 4'hF, 4'h0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 3'd1, 8'd3, 4'hF, 4'h0, 4'h2};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 4'h0, 4'hF, 4'h0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 4'hF, 4'h0, 4'h0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 4'h2, 4'hD, 4'h0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 4'hD, 4'h2, 4'h0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 4'h2, 4'hD, 4'h0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 3'd7, 8'd9, 4'hF, 4'h0, 4'h0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 4'h0, 4'hF, 4'h0};

    for (int r = 0; r < 14; r++) begin
      rst = tbl[r].rst; ena = tbl[r].ena; wr_en = tbl[r].we;
      wr_ch = tbl[r].ch; wr_data = tbl[r].d;
      cycle();
      chk($sformatf("tbl%0d_div", r),  8'(div_out), 8'(tbl[r].ediv));
      chk($sformatf("tbl%0d_tick", r), 8'(tick),    8'(tbl[r].etick));
      chk($sformatf("tbl%0d_busy", r), 8'(busy),    8'(tbl[r].ebusy));
    end
    wr_en = 1'b0;

    // ch2: disable via D=0 at the next wrap, then D=5 loads immediately.
    wr_en = 1'b1; wr_ch = 3'd2; wr_data = 8'd0;
    cycle();
    wr_en = 1'b0;
    chk("dis_busy", 8'(busy[2]), 8'd1);
    chk("dis_div0", 8'(div_out[2]), 8'd1);
    cycle();
    chk("dis_wrap_tick", 8'(tick[2]), 8'd1);
    chk("dis_wrap_busy", 8'(busy[2]), 8'd0);
    cycle();
    chk("dis_off_div",  8'(div_out[2]), 8'd0);
    chk("dis_off_tick", 8'(tick[2]), 8'd0);
    wr_en = 1'b1; wr_ch = 3'd2; wr_data = 8'd5;
    cycle();
    wr_en = 1'b0;
    chk("en5_busy", 8'(busy[2]), 8'd0);
    chk("en5_div",  8'(div_out[2]), 8'd0);
    e5d = 5'b00111; e5t = 5'b10000;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk($sformatf("d5_div%0d", k),  8'(div_out[2]), 8'(e5d[k]));
      chk($sformatf("d5_tick%0d", k), 8'(tick[2]),    8'(e5t[k]));
      chk($sformatf("d5_busy%0d", k), 8'(busy[2]),    8'd0);
    end

    // Freeze ch2 at cnt=2 (outputs from cnt=1) for five cycles, then resume.
    cycle();
    cycle();
    ena = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk($sformatf("frz_div%0d", k),  8'(div_out[2]), 8'd1);
      chk($sformatf("frz_tick%0d", k), 8'(tick[2]),    8'd0);
    end
    ena = 1'b1;
    erd = 4'b1001; ert = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk($sformatf("res_div%0d", k),  8'(div_out[2]), 8'(erd[k]));
      chk($sformatf("res_tick%0d", k), 8'(tick[2]),    8'(ert[k]));
    end

`ifdef CLKDIV_PHASE_SYNC_EN
    wr_en = 1'b1; wr_ch = 3'd0; wr_data = 8'd4;
    cycle();
    wr_ch = 3'd1; wr_data = 8'd6;
    cycle();
    wr_en = 1'b0;
    repeat (15) cycle();
    sync_in = 1'b1;
    cycle();
    sync_in = 1'b0;
    cycle();
    chk("sync_div_a",  8'(div_out[1:0]), 8'd3);
    chk("sync_tick_a", 8'(tick[1:0]),    8'd0);
    cycle();
    chk("sync_div_b", 8'(div_out[1:0]), 8'd3);
    cycle();
    chk("sync_div_c", 8'(div_out[1:0]), 8'd2);
`endif

    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      ena     = ($urandom_range(0, 7) != 0);
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_ch   = 3'($urandom_range(0, 7));
      wr_data = ($urandom_range(0, 15) == 0) ? DW'($urandom_range(0, 255))
                                             : DW'($urandom_range(0, 7));
      sync_in = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
